// File: rtl/serial_pattern_generator.sv
// serial_pattern_generator
//   Serially emits a WIDTH-bit pattern MSB first, one bit per clock, repeated
//   reps times with GAP idle cycles between repetitions. The serial stream is
//   intended to feed the input of the FSM sequence detectors.
//
// Ports
//   clk_i        single clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      burst request, sampled only while idle
//   pattern_i    bits to send, latched on an accepted start
//   reps_i       repetition count, latched on an accepted start (0 is legal)
//   bit_out_o    serial data bit, 0 whenever bit_valid_o is 0
//   bit_valid_o  bit_out_o carries a pattern bit this cycle
//   busy_o       high whenever the generator is not idle
//   done_o       one-cycle pulse at the end of a burst

module serial_pattern_generator #(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned GAP   = 0,
   parameter int unsigned REP_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [WIDTH-1:0] pattern_i,
   input  logic [REP_W-1:0] reps_i,
   output logic             bit_out_o,
   output logic             bit_valid_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
   // Unused when GAP is 0: the gap state is never entered then.
   localparam logic [3:0] GapLast = 4'(GAP - 1);

   typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [3:0]       gap_cnt_q, gap_cnt_d;
   logic             bit_out_q, bit_out_d;
   logic             bit_valid_q, bit_valid_d;
   logic             done_q, done_d;

   // The state register names the cycle currently on the outputs: entering
   // StSend also presents the first bit, and shift_q holds the bits still
   // to come in this repetition. rep_cnt_q counts repetitions left,
   // including the one being sent.
   always_comb begin
      state_d     = state_q;
      pat_d       = pat_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      rep_cnt_d   = rep_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      bit_out_d   = 1'b0;
      bit_valid_d = 1'b0;
      done_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               if (reps_i != '0) begin
                  pat_d       = pattern_i;
                  rep_cnt_d   = reps_i;
                  bit_out_d   = pattern_i[WIDTH-1];
                  bit_valid_d = 1'b1;
                  shift_d     = pattern_i << 1;
                  bit_cnt_d   = '0;
                  state_d     = StSend;
               end else begin
                  done_d  = 1'b1;
                  state_d = StDone;
               end
            end
         end

         StSend: begin
            if (bit_cnt_q == LastBit) begin
               rep_cnt_d = rep_cnt_q - REP_W'(1);
               if (rep_cnt_q == REP_W'(1)) begin
                  done_d  = 1'b1;
                  state_d = StDone;
               end else if (GAP == 0) begin
                  // Back-to-back: the next repetition's MSB follows directly.
                  bit_out_d   = pat_q[WIDTH-1];
                  bit_valid_d = 1'b1;
                  shift_d     = pat_q << 1;
                  bit_cnt_d   = '0;
               end else begin
                  gap_cnt_d = '0;
                  state_d   = StGap;
               end
            end else begin
               bit_out_d   = shift_q[WIDTH-1];
               bit_valid_d = 1'b1;
               shift_d     = shift_q << 1;
               bit_cnt_d   = bit_cnt_q + CntW'(1);
            end
         end

         StGap: begin
            if (gap_cnt_q == GapLast) begin
               bit_out_d   = pat_q[WIDTH-1];
               bit_valid_d = 1'b1;
               shift_d     = pat_q << 1;
               bit_cnt_d   = '0;
               state_d     = StSend;
            end else begin
               gap_cnt_d = gap_cnt_q + 4'd1;
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         pat_q       <= '0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         rep_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pat_q       <= pat_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         rep_cnt_q   <= rep_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         bit_out_q   <= bit_out_d;
         bit_valid_q <= bit_valid_d;
         done_q      <= done_d;
      end
   end

   assign bit_out_o   = bit_out_q;
   assign bit_valid_o = bit_valid_q;
   assign busy_o      = (state_q != StIdle);
   assign done_o      = done_q;

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Bench for serial_pattern_generator: one instance with GAP=0 and one with
// GAP=2, compared cycle by cycle against a timeline computed from the
// burst arithmetic (bit k of repetition r at offset 1 + r*(W+GAP) + k).

module tb_serial_pattern_generator;

   logic       clk;
   logic       rst_n;
   logic       start_a, start_b;
   logic [5:0] pattern;
   logic [3:0] reps;
   logic       bit_a, valid_a, busy_a, done_a;
   logic       bit_b, valid_b, busy_b, done_b;

   int checks = 0;
   int errors = 0;

   // Captured {busy, done, valid, bit} per cycle after the accepting edge.
   logic [3:0] cap [1:128];

   serial_pattern_generator #(.WIDTH(6), .GAP(0), .REP_W(4)) dut_a (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start_a),
      .pattern_i  (pattern),
      .reps_i     (reps),
      .bit_out_o  (bit_a),
      .bit_valid_o(valid_a),
      .busy_o     (busy_a),
      .done_o     (done_a)
   );

   serial_pattern_generator #(.WIDTH(6), .GAP(2), .REP_W(4)) dut_b (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start_b),
      .pattern_i  (pattern),
      .reps_i     (reps),
      .bit_out_o  (bit_b),
      .bit_valid_o(valid_b),
      .busy_o     (busy_b),
      .done_o     (done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] obs(input bit sel);
      return sel ? {busy_b, done_b, valid_b, bit_b} : {busy_a, done_a, valid_a, bit_a};
   endfunction

   function automatic int burst_len(input int r, input int gap);
      return (r == 0) ? 0 : r * 6 + (r - 1) * gap;
   endfunction

   // Expected {busy, done, valid, bit} at cycle c (1 = cycle after acceptance).
   function automatic logic [3:0] model(input logic [5:0] pat, input int r, input int gap,
                                        input int c);
      int len;
      int p;
      len = burst_len(r, gap);
      if (r == 0) return (c == 1) ? 4'b1100 : 4'b0000;
      if (c <= len) begin
         p = (c - 1) % (6 + gap);
         if (p < 6) return {3'b101, pat[5-p]};
         return 4'b1000;
      end
      if (c == len + 1) return 4'b1100;
      return 4'b0000;
   endfunction

   // Start a burst on the selected instance, scramble the inputs right after
   // acceptance, and record n cycles. A second start is raised during cycle
   // restart_at when it is non-zero.
   task automatic run_burst(input bit sel, input logic [5:0] pat, input logic [3:0] r,
                            input int n, input int restart_at);
      @(negedge clk);
      pattern = pat;
      reps    = r;
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
      pattern = 6'($urandom);
      reps    = 4'($urandom);
      for (int c = 1; c <= n; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         cap[c] = obs(sel);
         if (c == restart_at) begin
            pattern = 6'b000000;
            reps    = 4'd5;
            if (sel) start_b = 1'b1; else start_a = 1'b1;
         end else if (c == restart_at + 1) begin
            start_a = 1'b0;
            start_b = 1'b0;
         end
      end
   endtask

   task automatic test_reset;
      rst_n   = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      pattern = '0;
      reps    = '0;
      #12;
      checks++;
      if (obs(0) !== 4'b0000) begin
         errors++;
         $display("FAIL reset_a got=%b exp=0000", obs(0));
      end
      checks++;
      if (obs(1) !== 4'b0000) begin
         errors++;
         $display("FAIL reset_b got=%b exp=0000", obs(1));
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (obs(0) !== 4'b0000) begin
         errors++;
         $display("FAIL post_reset_idle got=%b exp=0000", obs(0));
      end
   endtask

   task automatic test_single;
      run_burst(0, 6'b110011, 4'd1, 9, 0);
      for (int c = 1; c <= 9; c++) begin
         checks++;
         if (cap[c] !== model(6'b110011, 1, 0, c)) begin
            errors++;
            $display("FAIL single c=%0d got=%b exp=%b", c, cap[c], model(6'b110011, 1, 0, c));
         end
      end
   endtask

   task automatic test_random;
      bit         sel;
      logic [5:0] pat;
      int         r;
      int         gap;
      int         n;
      for (int it = 0; it < 16; it++) begin
         sel = 1'($urandom_range(0, 1));
         pat = 6'($urandom);
         r   = $urandom_range(0, 4);
         gap = sel ? 2 : 0;
         n   = burst_len(r, gap) + 2;
         run_burst(sel, pat, 4'(r), n, 0);
         for (int c = 1; c <= n; c++) begin
            checks++;
            if (cap[c] !== model(pat, r, gap, c)) begin
               errors++;
               $display("FAIL random it=%0d sel=%0d pat=%b reps=%0d c=%0d got=%b exp=%b",
                        it, sel, pat, r, c, cap[c], model(pat, r, gap, c));
            end
         end
      end
   endtask

   task automatic test_loopback;
      logic [5:0] win;
      int         nbits;
      int         hits[$];
      nbits = 0;
      win   = '0;
      run_burst(0, 6'b110011, 4'd3, 20, 0);
      for (int c = 1; c <= 20; c++) begin
         if (cap[c][1]) begin
            nbits++;
            win = {win[4:0], cap[c][0]};
            if (nbits >= 6 && win == 6'b110011) hits.push_back(nbits);
         end
      end
      checks++;
      if (nbits != 18 || cap[19] !== 4'b1100) begin
         errors++;
         $display("FAIL loopback_stream bits=%0d done_cycle=%b exp bits=18 done=1100",
                  nbits, cap[19]);
      end
      checks++;
      if (hits.size() != 3) begin
         errors++;
         $display("FAIL loopback_hits got=%0d exp=3", hits.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (hits[i] != 6 * (i + 1)) begin
               errors++;
               $display("FAIL loopback_pos i=%0d got=%0d exp=%0d", i, hits[i], 6 * (i + 1));
            end
         end
      end
   endtask

   task automatic test_gap;
      run_burst(1, 6'b101010, 4'd2, 17, 0);
      for (int c = 1; c <= 17; c++) begin
         checks++;
         if (cap[c] !== model(6'b101010, 2, 2, c)) begin
            errors++;
            $display("FAIL gap c=%0d got=%b exp=%b", c, cap[c], model(6'b101010, 2, 2, c));
         end
      end
      checks++;
      if (cap[7] !== 4'b1000 || cap[8] !== 4'b1000 || cap[15] !== 4'b1100) begin
         errors++;
         $display("FAIL gap_slots c7=%b c8=%b c15=%b exp 1000 1000 1100",
                  cap[7], cap[8], cap[15]);
      end
   endtask

   task automatic test_zero_and_ignored;
      int dones;
      run_burst(0, 6'b111111, 4'd0, 4, 0);
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if (cap[c] !== model(6'b111111, 0, 0, c)) begin
            errors++;
            $display("FAIL zero_reps c=%0d got=%b exp=%b", c, cap[c], model(6'b111111, 0, 0, c));
         end
      end
      run_burst(0, 6'b110011, 4'd1, 14, 3);
      dones = 0;
      for (int c = 1; c <= 14; c++) begin
         if (cap[c][2]) dones++;
         checks++;
         if (cap[c] !== model(6'b110011, 1, 0, c)) begin
            errors++;
            $display("FAIL ignored_start c=%0d got=%b exp=%b", c, cap[c],
                     model(6'b110011, 1, 0, c));
         end
      end
      checks++;
      if (dones != 1) begin
         errors++;
         $display("FAIL ignored_start_dones got=%0d exp=1", dones);
      end
   endtask

   task automatic test_reset_mid;
      logic [5:0] pat;
      @(negedge clk);
      pattern = 6'b111111;
      reps    = 4'd2;
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      checks++;
      if (obs(0) !== 4'b1011) begin
         errors++;
         $display("FAIL mid_third_bit got=%b exp=1011", obs(0));
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs(0) !== 4'b0000) begin
         errors++;
         $display("FAIL mid_reset_async got=%b exp=0000", obs(0));
      end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (obs(0) !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_hold i=%0d got=%b exp=0000", i, obs(0));
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (obs(0) !== 4'b0000) begin
            errors++;
            $display("FAIL mid_no_done i=%0d got=%b exp=0000", i, obs(0));
         end
      end
      pat = 6'b100110;
      run_burst(0, pat, 4'd1, 9, 0);
      for (int c = 1; c <= 9; c++) begin
         checks++;
         if (cap[c] !== model(pat, 1, 0, c)) begin
            errors++;
            $display("FAIL mid_restart c=%0d got=%b exp=%b", c, cap[c], model(pat, 1, 0, c));
         end
      end
   endtask

   task automatic test_max_reps;
      int nvalid;
      int nones;
      nvalid = 0;
      nones  = 0;
      run_burst(0, 6'b000001, 4'd15, 93, 0);
      for (int c = 1; c <= 93; c++) begin
         if (cap[c][1]) nvalid++;
         if (cap[c][0]) nones++;
      end
      checks++;
      if (nvalid != 90 || nones != 15) begin
         errors++;
         $display("FAIL max_reps_counts valid=%0d ones=%0d exp 90 15", nvalid, nones);
      end
      checks++;
      if (cap[91] !== 4'b1100 || cap[92] !== 4'b0000) begin
         errors++;
         $display("FAIL max_reps_done c91=%b c92=%b exp 1100 0000", cap[91], cap[92]);
      end
      for (int c = 1; c <= 93; c++) begin
         checks++;
         if (cap[c] !== model(6'b000001, 15, 0, c)) begin
            errors++;
            $display("FAIL max_reps c=%0d got=%b exp=%b", c, cap[c],
                     model(6'b000001, 15, 0, c));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_loopback();
      test_gap();
      test_zero_and_ignored();
      test_random();
      test_reset_mid();
      test_max_reps();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
